instr_fetch: RTL and testbench

//  Instruction-fetch front end: the producer of the 32-bit Instr word that the single-cycle core consumes.

---
 rtl/proc_pkg.sv | 28 ++
 rtl/ifetch_fifo.sv | 73 +++++++
 rtl/instr_fetch.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Optional build macro: IFETCH_PERF_EN (adds fetch/flush performance counters).
package proc_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic {RUN, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Branch offset is in words, relative to the instruction after the branch.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + PC_INC + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer: synchronous FIFO of fetch entries with flush.
// Head is read combinationally from registered storage; flush wins over push/pop.
module ifetch_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q,  count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Simultaneous push and pop is allowed when full: the slot being read frees up.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: PC, credit-limited imem requests, response buffer, branch redirect.
// Optional build macro: IFETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               redirect,
  input  logic [15:0]        redirect_imm
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  fetch_state_t  state_q, state_d;
  logic          en_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   target_q, target_d;
  logic          pend_q, pend_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_head, push_entry;

  logic [SW-1:0] credit_sum;
  logic          req_fire, consume, redirect_fire;
  logic          rsp_from_out, rsp_in_drain, rsp_push, rsp_drop, accept_wrong;
  logic [31:0]   target;
  logic [CW-1:0] out_base, disc_base;

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Buffered, in-flight and to-be-dropped words all hold a slot; this sum can
  // only grow on an accepted request, so a raised valid never drops unaccepted.
  assign credit_sum     = SW'(fifo_count) + SW'(outstanding_q) + SW'(discard_q);
  assign imem_req_valid = en_q && (credit_sum < SW'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid    = !fifo_empty;
  assign instr          = instr_valid ? fifo_head.instr : '0;
  assign instr_pc       = instr_valid ? fifo_head.pc    : '0;
  assign consume        = instr_valid && instr_ready;
  assign redirect_fire  = consume && redirect;
  assign target         = branch_target(fifo_head.pc, redirect_imm);

  assign rsp_in_drain   = imem_rsp_valid && (state_q == DRAIN);
  assign rsp_from_out   = imem_rsp_valid && (state_q == RUN);
  assign rsp_push       = rsp_from_out && !redirect_fire;
  assign rsp_drop       = imem_rsp_valid && !rsp_push;
  assign accept_wrong   = req_fire && (pend_q || redirect_fire);

  assign push_entry     = '{instr: imem_rsp_data, pc: rsp_pc_q};
  assign fifo_push      = rsp_push && (!fifo_full || fifo_pop);
  assign fifo_pop       = consume;
  assign fifo_flush     = redirect_fire;

  assign disc_base      = discard_q - CW'(rsp_in_drain);
  assign out_base       = outstanding_q - CW'(rsp_from_out);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    target_d      = target_q;
    pend_d        = pend_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    // A request stalled across a redirect keeps its old address; the target
    // is parked until that stale request is accepted.
    if (pend_q) begin
      if (req_fire) begin
        fetch_pc_d = target_q;
        pend_d     = 1'b0;
      end
    end else if (redirect_fire) begin
      if (imem_req_valid && !imem_req_ready) begin
        pend_d   = 1'b1;
        target_d = target;
      end else begin
        fetch_pc_d = target;
      end
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end

    if (redirect_fire) begin
      discard_d     = disc_base + out_base + CW'(req_fire);
      outstanding_d = '0;
      rsp_pc_d      = target;
    end else begin
      discard_d     = disc_base + CW'(accept_wrong);
      outstanding_d = out_base + CW'(req_fire && !accept_wrong);
      if (rsp_push) rsp_pc_d = rsp_pc_q + PC_INC;
    end

    case (state_q)
      RUN:     if (discard_d != '0) state_d = DRAIN;
      DRAIN:   if (discard_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      en_q          <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      target_q      <= '0;
      pend_q        <= 1'b0;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      target_q      <= target_d;
      pend_q        <= pend_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;
  logic [31:0] flush_inc;

  // The consumed branch itself is not a flushed entry.
  assign flush_inc = 32'(rsp_drop) +
                     (redirect_fire ? (32'(fifo_count) - 32'd1) : 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= sat_add(perf_fetched_q, 32'(fifo_push));
      perf_flushed_q <= sat_add(perf_flushed_q, flush_inc);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a default-reset instance and a wrap-around RESET_PC instance,
// each driven by an in-order queue memory that returns ~addr as data.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, rsp_valid;
  logic [31:0] req_addr, rsp_data;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, instr_pc;
  logic [15:0] redirect_imm;
  logic        hold;

  logic        w_req_valid, w_rsp_valid;
  logic [31:0] w_req_addr, w_rsp_data;
  logic        w_instr_valid;
  logic [31:0] w_instr, w_instr_pc;
  logic        w_req_ready = 1'b1;
  logic        w_instr_ready = 1'b1;
  logic        w_redirect = 1'b0;
  logic [15:0] w_redirect_imm = 16'h0;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, w_perf_fetched, w_perf_flushed;
`endif

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_imm(redirect_imm)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc),
    .redirect(w_redirect), .redirect_imm(w_redirect_imm)
`ifdef IFETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_flushed(w_perf_flushed)
`endif
  );

  // In-order memories, latency 1 unless held.
  logic [31:0] mq[$];
  logic [31:0] wq[$];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (req_valid && req_ready) mq.push_back(req_addr);
      if (!hold && mq.size() > 0) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ~mq.pop_front();
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wq.delete();
      w_rsp_valid <= 1'b0;
      w_rsp_data  <= '0;
    end else begin
      if (w_req_valid && w_req_ready) wq.push_back(w_req_addr);
      if (wq.size() > 0) begin
        w_rsp_valid <= 1'b1;
        w_rsp_data  <= ~wq.pop_front();
      end else begin
        w_rsp_valid <= 1'b0;
      end
    end
  end

  // Handshake logs, sampled mid-cycle.
  logic [31:0] acc_q[$], cpc_q[$], cins_q[$], w_acc_q[$], w_cpc_q[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready) acc_q.push_back(req_addr);
      if (instr_valid && instr_ready) begin
        cpc_q.push_back(instr_pc);
        cins_q.push_back(instr);
        $display("%0t consume pc=%h instr=%h redirect=%0b", $time, instr_pc, instr, redirect);
      end
      if (w_req_valid && w_req_ready) w_acc_q.push_back(w_req_addr);
      if (w_instr_valid && w_instr_ready) w_cpc_q.push_back(w_instr_pc);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    cpc_q.delete();
    cins_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    req_ready    = 1'b1;
    instr_ready  = 1'b1;
    redirect     = 1'b0;
    redirect_imm = 16'h0;
    hold         = 1'b0;
    cyc(2);

    // Reset values
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);

    // Streaming from reset, plus the wrap-around instance
    reset = 1'b0;
    clear_logs();
    w_acc_q.delete();
    w_cpc_q.delete();
    cyc(1);
    chk("c1_req_valid", 32'(req_valid), 32'h1);
    chk("c1_req_addr", req_addr, 32'h0);
    cyc(1);
    chk("c2_instr_valid", 32'(instr_valid), 32'h0);
    cyc(1);
    chk("c3_instr_valid", 32'(instr_valid), 32'h1);
    chk("c3_instr_pc", instr_pc, 32'h0);
    chk("c3_instr", instr, 32'hFFFF_FFFF);
    cyc(10);
    chk("seq_acc0", acc_q[0], 32'h0);
    chk("seq_acc1", acc_q[1], 32'h4);
    chk("seq_acc2", acc_q[2], 32'h8);
    chk("seq_acc3", acc_q[3], 32'hC);
    chk("seq_pc1", cpc_q[1], 32'h4);
    chk("seq_pc3", cpc_q[3], 32'hC);
    chk("seq_ins2", cins_q[2], ~32'h8);
    chk("wrap_acc0", w_acc_q[0], 32'hFFFF_FFF8);
    chk("wrap_acc1", w_acc_q[1], 32'hFFFF_FFFC);
    chk("wrap_acc2", w_acc_q[2], 32'h0000_0000);
    chk("wrap_pc2", w_cpc_q[2], 32'h0000_0000);

    // Core stalled: credit limits requests to FIFO_DEPTH; ignored redirect
    instr_ready = 1'b0;
    do_reset();
    cyc(5);
    redirect     = 1'b1;
    redirect_imm = 16'h0003;
    cyc(1);
    redirect     = 1'b0;
    redirect_imm = 16'h0;
    cyc(4);
    chk("stall_nreq", 32'(acc_q.size()), 32'd2);
    chk("stall_req_valid", 32'(req_valid), 32'h0);
    chk("stall_instr_valid", 32'(instr_valid), 32'h1);
    chk("stall_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    cyc(12);
    chk("resume_pc0", cpc_q[0], 32'h0);
    chk("resume_pc1", cpc_q[1], 32'h4);
    chk("resume_pc2", cpc_q[2], 32'h8);
    chk("resume_pc3", cpc_q[3], 32'hC);
    chk("resume_pc4", cpc_q[4], 32'h10);
    chk("resume_ins4", cins_q[4], ~32'h10);

    // Backward branch at pc 0x10 with imm -2 words -> target 0x0C
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (instr_valid && instr_pc == 32'h10) break;
      cyc(1);
    end
    chk("wait_pc10", instr_pc, 32'h10);
    redirect     = 1'b1;
    redirect_imm = 16'hFFFE;
    cyc(1);
    redirect     = 1'b0;
    redirect_imm = 16'h0;
    clear_logs();
    cyc(12);
    chk("br_first_req", acc_q[0], 32'hC);
    chk("br_first_pc", cpc_q[0], 32'hC);
    chk("br_first_ins", cins_q[0], ~32'hC);
    chk("br_second_pc", cpc_q[1], 32'h10);
`ifdef IFETCH_PERF_EN
    chk("br_perf_flushed", perf_flushed, 32'd1);
`endif

    // Redirect while a request is stalled by the memory
    instr_ready = 1'b0;
    req_ready   = 1'b1;
    do_reset();
    cyc(6);
    chk("pend_fill_nreq", 32'(acc_q.size()), 32'd2);
    req_ready   = 1'b0;
    instr_ready = 1'b1;
    cyc(1);
    chk("pend_req_valid", 32'(req_valid), 32'h1);
    chk("pend_req_addr", req_addr, 32'h8);
    chk("pend_head_pc", instr_pc, 32'h4);
    redirect     = 1'b1;
    redirect_imm = 16'h0003;
    cyc(1);
    redirect     = 1'b0;
    redirect_imm = 16'h0;
    clear_logs();
    chk("pend_hold_valid", 32'(req_valid), 32'h1);
    chk("pend_hold_addr0", req_addr, 32'h8);
    cyc(2);
    chk("pend_hold_addr2", req_addr, 32'h8);
    chk("pend_flushed", 32'(instr_valid), 32'h0);
    req_ready = 1'b1;
    cyc(10);
    chk("pend_acc0", acc_q[0], 32'h8);
    chk("pend_acc1", acc_q[1], 32'h14);
    chk("pend_first_pc", cpc_q[0], 32'h14);
    chk("pend_first_ins", cins_q[0], ~32'h14);

    // Asynchronous reset with two reads outstanding
    hold = 1'b1;
    cyc(8);
    chk("out2_req_valid", 32'(req_valid), 32'h0);
    chk("out2_instr_valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_req_valid", 32'(req_valid), 32'h0);
    chk("arst_req_addr", req_addr, 32'h0);
    chk("arst_instr_pc", instr_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    chk("arst_perf_fetched", perf_fetched, 32'h0);
    chk("arst_perf_flushed", perf_flushed, 32'h0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    hold = 1'b0;
    clear_logs();
    cyc(10);
    chk("rerun_acc0", acc_q[0], 32'h0);
    chk("rerun_pc0", cpc_q[0], 32'h0);
    chk("rerun_pc1", cpc_q[1], 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
